i2s_sample_tx: RTL and testbench

- Transmit end of the audio sample path. Accepts 16-bit signed samples from the synth voice path through a valid/ready handshake and buffers them in a small FIFO.
- Serializes the samples onto the codec data line in standard I2S format, slaved to the codec-supplied I2S_SCLK and I2S_LRCLK.
- Output is mono: the same sample is sent in both left and right slots of a frame.
- Also produces a once-per-frame sample request pulse for the generator side.

---
 rtl/i2s_sample_tx.sv | 127 ++++++++++++
 tb/tb_i2s_sample_tx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: buffered mono I2S transmitter slaved to codec SCLK/LRCLK.
// Define I2S_SAMPLE_TX_HOLD_EN to repeat the last sample on underrun (default: send zeros).
module i2s_sample_tx #(
    parameter int SAMPLE_W    = 16,
    parameter int FIFO_DEPTH  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                Reset_n,
    input  logic                I2S_SCLK,
    input  logic                I2S_LRCLK,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                mute,
    output logic                I2S_DIN,
    output logic                frame_start,
    output logic                underrun
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(SAMPLE_W + 1);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sclk_sync, lr_sync;
    logic                   sclk_q, sfall, lr, lr_q;
    logic [SAMPLE_W-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CNTW-1:0]        count, count_n;
    logic [SAMPLE_W-1:0]    held, held_n, shift, miss;
    logic [CW-1:0]          cnt;
    logic                   left_start, right_start, bit_step, push, pop, empty;

    assign sfall   = sclk_q & ~sclk_sync[SYNC_STAGES-1];
    assign lr      = lr_sync[SYNC_STAGES-1];
    assign empty   = count == '0;
    assign push    = sample_valid & sample_ready;
    assign pop     = left_start & ~empty;
    assign count_n = count + CNTW'(push) - CNTW'(pop);

`ifdef I2S_SAMPLE_TX_HOLD_EN
    assign miss = held;
`else
    assign miss = '0;
`endif

    assign held_n = left_start ? (empty ? miss : mem[rd_ptr]) : held;

    always_comb begin
        state_n     = state;
        left_start  = 1'b0;
        right_start = 1'b0;
        bit_step    = 1'b0;
        if (sfall) begin
            case (state)
                IDLE: begin
                    left_start = ~lr & lr_q;
                    state_n    = left_start ? LEFT : IDLE;
                end
                LEFT: begin
                    right_start = lr & ~lr_q;
                    bit_step    = ~right_start;
                    state_n     = right_start ? RIGHT : LEFT;
                end
                RIGHT: begin
                    left_start = ~lr & lr_q;
                    bit_step   = ~left_start;
                    state_n    = left_start ? LEFT : RIGHT;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state        <= IDLE;
            sclk_sync    <= '0;
            lr_sync      <= '0;
            sclk_q       <= 1'b0;
            lr_q         <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            sample_ready <= 1'b0;
            held         <= '0;
            shift        <= '0;
            cnt          <= '0;
            I2S_DIN      <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state        <= state_n;
            sclk_sync    <= {sclk_sync[SYNC_STAGES-2:0], I2S_SCLK};
            lr_sync      <= {lr_sync[SYNC_STAGES-2:0], I2S_LRCLK};
            sclk_q       <= sclk_sync[SYNC_STAGES-1];
            lr_q         <= sfall ? lr : lr_q;
            frame_start  <= left_start;
            underrun     <= left_start & empty;
            held         <= held_n;
            count        <= count_n;
            sample_ready <= count_n != CNTW'(FIFO_DEPTH);
            if (push) begin
                mem[wr_ptr] <= sample_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            // Each slot opens with the I2S one-bit delay, then MSB-first data, then zero padding.
            if (left_start || right_start) begin
                shift   <= mute ? '0 : held_n;
                cnt     <= '0;
                I2S_DIN <= 1'b0;
            end else if (bit_step) begin
                if (cnt < CW'(SAMPLE_W)) begin
                    I2S_DIN <= shift[SAMPLE_W-1];
                    shift   <= shift << 1;
                    cnt     <= cnt + 1'b1;
                end else begin
                    I2S_DIN <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_sample_tx.sv
// tb_i2s_sample_tx: table-driven frame vectors plus hand sequences for FIFO backpressure and mid-slot reset.
module tb_i2s_sample_tx;
    logic        clk = 1'b0, Reset_n = 1'b0, I2S_SCLK = 1'b1, I2S_LRCLK = 1'b1;
    logic        sample_valid = 1'b0, mute = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_ready, I2S_DIN, frame_start, underrun;
    int          tests = 0, fails = 0, fs_tot = 0, ur_tot = 0;

    typedef struct {
        logic        do_push;
        logic [15:0] s;
        logic        m;
        int          n;
        logic [63:0] el, er;
        int          ur;
    } vec_t;

    vec_t tv [6];

    always #5 clk = ~clk;

    i2s_sample_tx dut (
        .clk(clk), .Reset_n(Reset_n), .I2S_SCLK(I2S_SCLK), .I2S_LRCLK(I2S_LRCLK),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .mute(mute), .I2S_DIN(I2S_DIN), .frame_start(frame_start), .underrun(underrun)
    );

    always @(negedge clk) begin
        if (frame_start) fs_tot++;
        if (underrun) ur_tot++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One SCLK period: fall (LRCLK changes with it), low phase, rise where the codec samples DIN.
    task automatic sclk_cycle(input logic lrv, output logic d);
        @(negedge clk);
        I2S_SCLK  = 1'b0;
        I2S_LRCLK = lrv;
        repeat (5) @(negedge clk);
        I2S_SCLK = 1'b1;
        d        = I2S_DIN;
        repeat (4) @(negedge clk);
    endtask

    task automatic slot(input logic lrv, input int n, output logic [63:0] v);
        logic d;
        v = '0;
        for (int i = 0; i < n; i++) begin
            sclk_cycle(lrv, d);
            v = {v[62:0], d};
        end
    endtask

    task automatic frame(input int n, output logic [63:0] l, output logic [63:0] r);
        slot(1'b0, n, l);
        slot(1'b1, n, r);
    endtask

    task automatic push(input logic [15:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        for (int i = 0; i < 1000 && !sample_ready; i++) @(negedge clk);
        chk("push_ready", 64'(sample_ready), 64'd1);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        #500us;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [63:0] l, r;
        int          f0, u0;
        logic        acc;
        tv[0] = '{1'b1, 16'h8001, 1'b0, 32, 64'h4000_8000, 64'h4000_8000, 0};
        tv[1] = '{1'b1, 16'hAAAA, 1'b0, 32, 64'h5555_0000, 64'h5555_0000, 0};
`ifdef I2S_SAMPLE_TX_HOLD_EN
        tv[2] = '{1'b0, 16'h0000, 1'b0, 32, 64'h5555_0000, 64'h5555_0000, 1};
`else
        tv[2] = '{1'b0, 16'h0000, 1'b0, 32, 64'h0, 64'h0, 1};
`endif
        tv[3] = '{1'b1, 16'h7FFF, 1'b1, 32, 64'h0, 64'h0, 0};
        tv[4] = '{1'b1, 16'hFFFF, 1'b0, 16, 64'h7FFF, 64'h7FFF, 0};
        tv[5] = '{1'b1, 16'h1234, 1'b0, 32, 64'h091A_0000, 64'h091A_0000, 0};

        repeat (4) @(negedge clk);
        chk("rst_din", 64'(I2S_DIN), 64'd0);
        chk("rst_ready", 64'(sample_ready), 64'd0);
        chk("rst_frame_start", 64'(frame_start), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        Reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 64'(sample_ready), 64'd1);
        slot(1'b1, 2, r);

        for (int i = 0; i < 6; i++) begin
            mute = tv[i].m;
            if (tv[i].do_push) push(tv[i].s);
            f0 = fs_tot;
            u0 = ur_tot;
            frame(tv[i].n, l, r);
            chk($sformatf("v%0d_left", i), l, tv[i].el);
            chk($sformatf("v%0d_right", i), r, tv[i].er);
            chk($sformatf("v%0d_frame_start", i), 64'(fs_tot - f0), 64'd1);
            chk($sformatf("v%0d_underrun", i), 64'(ur_tot - u0), 64'(tv[i].ur));
            mute = 1'b0;
        end

        push(16'h1234);
        push(16'h5678);
        chk("full_ready_low", 64'(sample_ready), 64'd0);
        sample_in    = 16'h0F0F;
        sample_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("third_waits", 64'(sample_ready), 64'd0);
        acc = 1'b0;
        fork
            frame(32, l, r);
            begin
                for (int i = 0; i < 1500; i++) begin
                    @(negedge clk);
                    if (sample_ready) begin
                        acc = 1'b1;
                        break;
                    end
                end
                @(negedge clk);
                sample_valid = 1'b0;
            end
        join
        chk("third_accepted", 64'(acc), 64'd1);
        chk("bp_first_left", l, 64'h091A_0000);
        frame(32, l, r);
        chk("bp_second_left", l, 64'h2B3C_0000);
        frame(32, l, r);
        chk("bp_third_left", l, 64'h0787_8000);

        push(16'hC3C3);
        slot(1'b0, 3, l);
        chk("pre_reset_bits", l, 64'h3);
        Reset_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_din", 64'(I2S_DIN), 64'd0);
        chk("mid_reset_ready", 64'(sample_ready), 64'd0);
        Reset_n = 1'b1;
        @(negedge clk);
        chk("mid_release_ready", 64'(sample_ready), 64'd1);
        push(16'h1234);
        f0 = fs_tot;
        u0 = ur_tot;
        slot(1'b0, 29, l);
        slot(1'b1, 32, r);
        chk("post_reset_left_rest", l, 64'h0);
        chk("post_reset_right", r, 64'h0);
        chk("post_reset_no_frame", 64'(fs_tot - f0), 64'd0);
        frame(32, l, r);
        chk("resume_left", l, 64'h091A_0000);
        chk("resume_frame_start", 64'(fs_tot - f0), 64'd1);
        chk("resume_underrun", 64'(ur_tot - u0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
